pingpong_audio_buffer: RTL and testbench
========================================

PINGPONG_AUDIO_BUFFER -- requirements
Module: pingpong_audio_buffer

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 100, frames per bank; legal range 2..4096.
REQ-003 Parameter CHANNELS, default 2, samples per frame; legal range 1..8.
REQ-004 Port clk  in  1  single clock for all logic.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port enable  in  1  playback enable.
REQ-007 Port wr_valid  in  1  write sample offered.
REQ-008 Port wr_data  in  DATA_W  write sample; channels arrive interleaved, channel 0 first.
REQ-009 Port wr_ready  out  1  fill bank can accept a sample.
REQ-010 Port sample_req  in  1  one-cycle codec request for the next frame.
REQ-011 Port audio_out  out  CHANNELS*DATA_W  frame; channel 0 occupies the LSBs.
REQ-012 Port out_valid  out  1  one-cycle strobe, audio_out updated.
REQ-013 Port irq  out  1  level interrupt: fill bank free.
REQ-014 Port irq_ack  in  1  clears irq.
REQ-015 Port underrun_cnt  out  16  count of frames substituted with silence.

Function
REQ-016 Storage SHALL be two banks of DEPTH×CHANNELS words; one bank is the fill bank, the other the play bank.
REQ-017 A write SHALL occur on wr_valid & wr_ready and store the sample at (wr_frame, wr_ch) of the fill bank.
- Then wr_ch increments.
- At CHANNELS-1, wr_ch wraps to 0 and wr_frame increments.
REQ-018 Completing the write at frame DEPTH-1, channel CHANNELS-1 SHALL set fill_full on the next edge.
- wr_frame and wr_ch return to 0.
- wr_ready = ~fill_full, combinational from the register.
REQ-019 The controller SHALL have two states, IDLE (no play bank) and PLAY.
REQ-020 IDLE with fill_full=1 SHALL perform a swap and enter PLAY.
- Swap: banks exchange roles, fill_full clears, rd_frame resets to 0, irq is set.
REQ-021 sample_req & enable in PLAY SHALL drive frame rd_frame onto audio_out with out_valid one cycle later (latency 1), then increment rd_frame.
REQ-022 A read of rd_frame = DEPTH-1 SHALL end the bank. The next state depends on the registered fill_full value in that cycle:
- fill_full=1: swap and stay in PLAY.
- fill_full=0: go to IDLE.
REQ-023 sample_req & enable in IDLE SHALL respond one cycle later as follows:
- audio_out = all zeros and out_valid = 1.
- underrun_cnt increments, saturating at 16'hFFFF.
REQ-024 sample_req with enable=0 SHALL be ignored: no out_valid, no pointer or counter change. Writes continue.
REQ-025 audio_out SHALL hold its last value between out_valid strobes.
REQ-026 irq SHALL stay high until irq_ack. If a set and irq_ack occur in the same cycle, the set wins.
REQ-027 A final write and a final read in the same cycle SHALL go to IDLE, because fill_full is not yet registered. A swap follows in the next cycle. No underrun occurs unless a sample_req lands in that IDLE cycle.
REQ-028 Index widths SHALL be $clog2(DEPTH) and $clog2(CHANNELS) (minimum 1). No pointer SHALL exceed DEPTH-1 or CHANNELS-1.
REQ-029 Writes SHALL never touch the play bank. Reads SHALL never touch the fill bank.

Reset
REQ-030 On reset_n=0 the following SHALL apply asynchronously:
- State=IDLE; fill_full, irq, out_valid = 0.
- audio_out = 0; underrun_cnt = 0.
- All pointers = 0; bank select = 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered data. Memory contents need not clear. No stale sample SHALL be output after release without being rewritten.
REQ-032 wr_ready SHALL be 1 in the first cycle after reset_n rises.

Verification (DATA_W=16, DEPTH=4, CHANNELS=2)
REQ-033 Write the 8 samples 1..8, then issue 4 spaced sample_req -> irq=1 one cycle after the fill completes; audio_out = 32'h0002_0001, 0004_0003, 0006_0005, 0008_0007, each with out_valid one cycle after its request.
REQ-034 sample_req with nothing written -> audio_out=0, out_valid=1, underrun_cnt=1; after 65540 requests, underrun_cnt=16'hFFFF.
REQ-035 Fill bank A, swap, fill bank B (wr_ready drops after the 8th write), drain A -> immediate swap to B, irq re-set, no underrun, and B's frames follow A's with no gap.
REQ-036 Final write and final read in the same cycle -> one IDLE cycle, then a swap; a sample_req in that IDLE cycle produces zero output and underrun_cnt+1.
REQ-037 irq set and irq_ack in the same cycle -> irq=1; irq_ack alone next cycle -> irq=0.
REQ-038 reset_n pulsed low mid-PLAY (no clk edge needed) -> all outputs reach reset values; the next sample_req yields zeros and underrun_cnt=1.

Source files
------------

// File: rtl/pingpong_audio_buffer.sv
// Double-buffered audio sample store: a writer fills one bank while the codec
// drains whole frames from the other; the banks swap roles when a fill completes.
module pingpong_audio_buffer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 100,
  parameter int CHANNELS = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       sample_req,
  output logic [CHANNELS*DATA_W-1:0] audio_out,
  output logic                       out_valid,
  output logic                       irq,
  input  logic                       irq_ack,
  output logic [15:0]                underrun_cnt
);

  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CH    = CW'(CHANNELS - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t state, state_next;

  logic              fill_sel;
  logic              fill_full;
  logic [FW-1:0]     wr_frame;
  logic [CW-1:0]     wr_ch;
  logic [FW-1:0]     rd_frame;
  logic [DATA_W-1:0] mem [0:1][0:DEPTH-1][0:CHANNELS-1];
  logic [CHANNELS*DATA_W-1:0] play_frame;

  logic rd_req;
  logic wr_fire;
  logic last_write;
  logic do_swap;
  logic do_play;
  logic do_underrun;

  assign wr_ready   = ~fill_full;
  assign wr_fire    = wr_valid & ~fill_full;
  assign last_write = wr_fire && (wr_frame == LAST_FRAME) && (wr_ch == LAST_CH);
  assign rd_req     = sample_req & enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // fill_full is used as registered, so a fill completing in the same cycle
  // as the last read is only seen one cycle later, from IDLE.
  always_comb begin
    state_next  = state;
    do_swap     = 1'b0;
    do_play     = 1'b0;
    do_underrun = 1'b0;
    case (state)
      IDLE: begin
        do_underrun = rd_req;
        if (fill_full) begin
          do_swap    = 1'b1;
          state_next = PLAY;
        end
      end
      PLAY: begin
        do_play = rd_req;
        if (rd_req && (rd_frame == LAST_FRAME)) begin
          if (fill_full) do_swap    = 1'b1;
          else           state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[fill_sel][wr_frame][wr_ch] <= wr_data;
  end

  always_comb begin
    play_frame = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      play_frame[ch*DATA_W +: DATA_W] = mem[~fill_sel][rd_frame][ch];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_frame  <= '0;
      wr_ch     <= '0;
      fill_full <= 1'b0;
      fill_sel  <= 1'b0;
    end else if (do_swap) begin
      fill_full <= 1'b0;
      fill_sel  <= ~fill_sel;
    end else if (last_write) begin
      wr_frame  <= '0;
      wr_ch     <= '0;
      fill_full <= 1'b1;
    end else if (wr_fire) begin
      if (wr_ch == LAST_CH) begin
        wr_ch    <= '0;
        wr_frame <= wr_frame + 1'b1;
      end else begin
        wr_ch <= wr_ch + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_frame     <= '0;
      audio_out    <= '0;
      out_valid    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      out_valid <= do_play | do_underrun;
      if (do_play) audio_out <= play_frame;
      else if (do_underrun) audio_out <= '0;
      if (do_underrun && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
      if (do_swap) rd_frame <= '0;
      else if (do_play) rd_frame <= (rd_frame == LAST_FRAME) ? '0 : rd_frame + 1'b1;
    end
  end

  // Setting wins over a simultaneous acknowledge so no bank-free event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     irq <= 1'b0;
    else if (do_swap) irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end

endmodule

// File: tb/tb_pingpong_audio_buffer.sv
// Self-checking bench for pingpong_audio_buffer: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pingpong_audio_buffer;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int CH = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             wr_valid = 1'b0;
  logic [DW-1:0]    wr_data = '0;
  logic             sample_req = 1'b0;
  logic             irq_ack = 1'b0;
  logic             wr_ready;
  logic [CH*DW-1:0] audio_out;
  logic             out_valid;
  logic             irq;
  logic [15:0]      underrun_cnt;

  int checks = 0;
  int errors = 0;

  pingpong_audio_buffer #(.DATA_W(DW), .DEPTH(DP), .CHANNELS(CH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .sample_req(sample_req),
    .audio_out(audio_out), .out_valid(out_valid), .irq(irq),
    .irq_ack(irq_ack), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: samples queue into the fill bank, a full bank becomes a
  // queue of frames, and the codec pops frames until that queue is empty.
  logic [DW-1:0]    m_fill[$];
  logic [CH*DW-1:0] m_play[$];
  bit               m_full, m_playing, m_irq, m_ov;
  logic [CH*DW-1:0] m_audio;
  logic [15:0]      m_ur;

  function automatic void modelReset();
    m_fill.delete();
    m_play.delete();
    m_full = 0; m_playing = 0; m_irq = 0; m_ov = 0;
    m_audio = '0; m_ur = '0;
  endfunction

  function automatic bit modelSwap();
    logic [CH*DW-1:0] fr;
    m_play.delete();
    for (int f = 0; f < DP; f++) begin
      fr = '0;
      for (int c = 0; c < CH; c++) fr[c*DW +: DW] = m_fill[f*CH + c];
      m_play.push_back(fr);
    end
    m_fill.delete();
    m_full = 0;
    m_playing = 1;
    return 1'b1;
  endfunction

  function automatic void modelStep(logic wv, logic [DW-1:0] wd, logic req, logic en, logic ack);
    bit old_full = m_full;
    bit pl = m_playing;
    bit set = 0;
    bit rd = req && en;
    m_ov = 0;
    if (wv && !old_full) begin
      m_fill.push_back(wd);
      if (m_fill.size() == DP*CH) m_full = 1;
    end
    if (rd) begin
      m_ov = 1;
      if (!pl) begin
        m_audio = '0;
        if (m_ur != 16'hFFFF) m_ur = m_ur + 16'd1;
      end else begin
        m_audio = m_play.pop_front();
      end
    end
    if (!pl) begin
      if (old_full) set = modelSwap();
    end else if (rd && m_play.size() == 0) begin
      if (old_full) set = modelSwap();
      else m_playing = 0;
    end
    if (set) m_irq = 1;
    else if (ack) m_irq = 0;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    checkVal({tag, ".audio_out"}, 32'(audio_out), 32'(m_audio));
    checkVal({tag, ".irq"}, 32'(irq), 32'(m_irq));
    checkVal({tag, ".wr_ready"}, 32'(wr_ready), 32'(!m_full));
    checkVal({tag, ".underrun"}, 32'(underrun_cnt), 32'(m_ur));
  endtask

  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic req,
                               input logic en, input logic ack);
    wr_valid = wv; wr_data = wd; sample_req = req; enable = en; irq_ack = ack;
    @(posedge clk);
    modelStep(wv, wd, req, en, ack);
    #1;
  endtask

  task automatic tick(input logic wv, input logic [DW-1:0] wd, input logic req,
                      input logic en, input logic ack, input bit chk, input string tag);
    applyStimulus(wv, wd, req, en, ack);
    if (chk) checkOutput(tag);
  endtask

  task automatic doReset();
    wr_valid = 0; wr_data = '0; sample_req = 0; enable = 0; irq_ack = 0;
    reset_n = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    modelReset();
  endtask

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          req;
    logic          en;
    logic          ack;
    logic          ov;
    logic [31:0]   audio;
    logic          irq;
    logic          ready;
    logic [15:0]   ur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wv, logic [DW-1:0] wd, logic req, logic en, logic ack,
                              logic ov, logic [31:0] audio, logic iq, logic ready, logic [15:0] ur);
    vec_t v;
    v.wv = wv; v.wd = wd; v.req = req; v.en = en; v.ack = ack;
    v.ov = ov; v.audio = audio; v.irq = iq; v.ready = ready; v.ur = ur;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] s;

    // Directed table: fill 1..8, swap, irq set/ack race, four reads, underrun.
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 16'(i + 1), 0, 1, 0, 0, 32'h0, 0, 1, 16'd0));
    vecs.push_back(mk(1, 16'd8, 0, 1, 0, 0, 32'h0, 0, 0, 16'd0));
    vecs.push_back(mk(0, 16'd0, 0, 1, 1, 0, 32'h0, 1, 1, 16'd0));
    vecs.push_back(mk(0, 16'd0, 1, 1, 1, 1, 32'h0002_0001, 0, 1, 16'd0));
    vecs.push_back(mk(0, 16'd0, 1, 0, 0, 0, 32'h0002_0001, 0, 1, 16'd0));
    vecs.push_back(mk(0, 16'd0, 1, 1, 0, 1, 32'h0004_0003, 0, 1, 16'd0));
    vecs.push_back(mk(0, 16'd0, 0, 1, 0, 0, 32'h0004_0003, 0, 1, 16'd0));
    vecs.push_back(mk(0, 16'd0, 1, 1, 0, 1, 32'h0006_0005, 0, 1, 16'd0));
    vecs.push_back(mk(0, 16'd0, 1, 1, 0, 1, 32'h0008_0007, 0, 1, 16'd0));
    vecs.push_back(mk(0, 16'd0, 1, 1, 0, 1, 32'h0, 0, 1, 16'd1));
    vecs.push_back(mk(0, 16'd0, 0, 1, 0, 0, 32'h0, 0, 1, 16'd1));
    vecs.push_back(mk(0, 16'd0, 1, 0, 0, 0, 32'h0, 0, 1, 16'd1));

    doReset();
    checkVal("reset.wr_ready", 32'(wr_ready), 32'd1);
    checkVal("reset.out_valid", 32'(out_valid), 32'd0);
    checkVal("reset.irq", 32'(irq), 32'd0);
    checkVal("reset.audio_out", 32'(audio_out), 32'd0);
    checkVal("reset.underrun", 32'(underrun_cnt), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].req, vecs[i].en, vecs[i].ack);
      checkVal($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      checkVal($sformatf("vec%0d.audio_out", i), 32'(audio_out), vecs[i].audio);
      checkVal($sformatf("vec%0d.irq", i), 32'(irq), 32'(vecs[i].irq));
      checkVal($sformatf("vec%0d.wr_ready", i), 32'(wr_ready), 32'(vecs[i].ready));
      checkVal($sformatf("vec%0d.underrun", i), 32'(underrun_cnt), 32'(vecs[i].ur));
    end

    // Ping-pong: fill A, swap, fill B, drain A back-to-back into B.
    doReset();
    for (int i = 0; i < 8; i++) tick(1, 16'hA000 + 16'(i), 0, 1, 0, 1, "pp.fillA");
    tick(0, 0, 0, 1, 1, 1, "pp.swapA");
    for (int i = 0; i < 8; i++) tick(1, 16'hB000 + 16'(i), 0, 1, 1, 1, "pp.fillB");
    checkVal("pp.wr_ready_low", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 1, 0, 1, "pp.drain");
    checkVal("pp.lastB", 32'(audio_out), 32'hB007_B006);
    checkVal("pp.no_underrun", 32'(underrun_cnt), 32'd0);
    checkVal("pp.irq_reset", 32'(irq), 32'd1);

    // Final write and final read in the same cycle.
    doReset();
    for (int i = 0; i < 8; i++) tick(1, 16'hA000 + 16'(i), 0, 1, 0, 1, "race.fillA");
    tick(0, 0, 0, 1, 0, 1, "race.swap");
    for (int i = 0; i < 4; i++) tick(1, 16'hB000 + 16'(i), 0, 1, 0, 1, "race.fillB");
    for (int i = 4; i < 7; i++) tick(1, 16'hB000 + 16'(i), 1, 1, 0, 1, "race.mix");
    tick(1, 16'hB007, 1, 1, 0, 1, "race.final");
    tick(0, 0, 1, 1, 0, 1, "race.idle_req");
    checkVal("race.idle_zero", 32'(audio_out), 32'h0);
    checkVal("race.idle_underrun", 32'(underrun_cnt), 32'd1);
    tick(0, 0, 1, 1, 0, 1, "race.readB");
    checkVal("race.firstB", 32'(audio_out), 32'hB001_B000);

    // Asynchronous reset in the middle of playback.
    doReset();
    tick(0, 0, 1, 1, 0, 1, "ar.pre_underrun");
    for (int i = 0; i < 8; i++) tick(1, 16'h5000 + 16'(i), 0, 1, 0, 1, "ar.fill");
    tick(0, 0, 0, 1, 0, 1, "ar.swap");
    tick(0, 0, 1, 1, 0, 1, "ar.read");
    #2;
    reset_n = 0;
    #1;
    checkVal("ar.out_valid", 32'(out_valid), 32'd0);
    checkVal("ar.audio_out", 32'(audio_out), 32'd0);
    checkVal("ar.irq", 32'(irq), 32'd0);
    checkVal("ar.underrun", 32'(underrun_cnt), 32'd0);
    checkVal("ar.wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1;
    modelReset();
    tick(0, 0, 1, 1, 0, 1, "ar.after");
    checkVal("ar.after_zero", 32'(audio_out), 32'd0);
    checkVal("ar.after_underrun", 32'(underrun_cnt), 32'd1);

    // Randomized traffic with varying write/read densities.
    for (int ph = 0; ph < 4; ph++) begin
      doReset();
      for (int i = 0; i < 600; i++) begin
        s = 16'($urandom);
        tick(($urandom % 4) < (ph + 1), s, ($urandom % 3) == 0, ($urandom % 8) != 0,
             ($urandom % 6) == 0, 1, $sformatf("rnd%0d", ph));
      end
    end

    // Underrun counter saturation.
    doReset();
    for (int i = 1; i <= 65540; i++) begin
      tick(0, 0, 1, 1, 0, 0, "sat");
      if (i == 65534) checkVal("sat.before", 32'(underrun_cnt), 32'hFFFE);
      if (i == 65535) checkVal("sat.reach", 32'(underrun_cnt), 32'hFFFF);
    end
    checkVal("sat.hold", 32'(underrun_cnt), 32'hFFFF);
    checkOutput("sat.final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
